vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_if.sv | 24 ++
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_if.sv
// Writer request channel plus the single-port VRAM bus driven by vram_arbiter.
interface vram_if #(
  parameter int ADDR_W = 17
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one VRAM port between display prefetch (2-word FIFO, priority) and a writer,
// and serialises the buffered words into 4-bit pixels.
module vram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int FRAME_WORDS = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       display_enable,
  input  logic       vsync,
  vram_if.slave      bus,
  output logic [3:0] pixel,
  output logic       underflow
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DREAD = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [1:0]        state_s;
  logic              slot_s;
  logic              fetch_s;
  logic              vsync_edge_s;
  logic              push_s;
  logic              pop_s;
  logic [15:0]       head_s;
  logic [ADDR_W-1:0] disp_addr_r;
  logic [1:0]        sel_r;
  logic [15:0]       fifo_r [0:1];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        occ_r;
  logic              inflight_r;
  logic              vsync_prev_r;

  // Arbitration for this cycle; the writer slot is offered whenever no fetch is due.
  always_comb begin
    vsync_edge_s = vsync & ~vsync_prev_r;
    fetch_s      = ({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd2;
    if (rst || vsync_edge_s) begin
      state_s = IDLE;
      slot_s  = 1'b0;
    end else if (fetch_s) begin
      state_s = DREAD;
      slot_s  = 1'b0;
    end else if (bus.wr_valid) begin
      state_s = WRITE;
      slot_s  = 1'b1;
    end else begin
      state_s = IDLE;
      slot_s  = 1'b1;
    end
  end

  // VRAM strobes decoded from the arbitration result.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 16'h0000;
    bus.wr_ready  = slot_s;
    case (state_s)
      DREAD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = disp_addr_r;
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.wr_addr;
        bus.mem_wdata = bus.wr_data;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  // FIFO push/pop qualifiers; a frame restart discards both the in-flight word and the head.
  always_comb begin
    head_s = fifo_r[rd_ptr_r];
    push_s = inflight_r & ~vsync_edge_s;
    pop_s  = display_enable & (occ_r != 2'd0) & (sel_r == 2'd3) & ~vsync_edge_s;
  end

  // Prefetch FIFO, display address, pixel serialiser and sticky underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_addr_r  <= '0;
      sel_r        <= 2'd0;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      occ_r        <= 2'd0;
      inflight_r   <= 1'b0;
      vsync_prev_r <= 1'b0;
      pixel        <= 4'd0;
      underflow    <= 1'b0;
    end else begin
      vsync_prev_r <= vsync;
      inflight_r   <= (state_s == DREAD);
      if (state_s == DREAD) begin
        disp_addr_r <= (disp_addr_r == LAST_ADDR) ? '0 : disp_addr_r + ADDR_W'(1);
      end
      if (vsync_edge_s) begin
        disp_addr_r <= '0;
        sel_r       <= 2'd0;
        rd_ptr_r    <= 1'b0;
        wr_ptr_r    <= 1'b0;
        occ_r       <= 2'd0;
        pixel       <= 4'd0;
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= bus.mem_rdata;
          wr_ptr_r         <= ~wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
        end
        occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
        if (!display_enable) begin
          pixel <= 4'd0;
        end else if (occ_r == 2'd0) begin
          pixel     <= 4'd0;
          underflow <= 1'b1;
        end else begin
          pixel <= head_s[{sel_r, 2'b00} +: 4];
          sel_r <= sel_r + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, corner sequences and a
// randomized run checked against a queue-based model of the display/writer rules.
module tb_vram_arbiter;
  localparam int FW = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       de = 1'b0;
  logic       vsync = 1'b0;
  logic [3:0] pixel;
  logic       underflow;

  vram_if #(.ADDR_W(17)) bus ();

  vram_arbiter #(.ADDR_W(17), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .display_enable(de), .vsync(vsync),
    .bus(bus.slave), .pixel(pixel), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] vram [0:1023];

  // reference model state
  logic [15:0] m_q [$];
  bit          m_pend;
  logic [15:0] m_pend_data;
  int          m_sel, m_daddr;
  bit          m_vprev, m_uf, mchk;
  logic [3:0]  m_pix;
  bit          e_en, e_we, e_rdy;
  logic [16:0] e_addr;
  logic [15:0] e_wdata;

  // samples taken each cycle before the edge
  logic        s_en, s_we, s_rdy, s_uf, s_acc;
  logic [16:0] s_addr;
  logic [15:0] s_wdata, rd_nxt;
  logic [3:0]  s_pix;

  typedef struct packed {
    logic        de;
    logic        en;
    logic [16:0] addr;
    logic [3:0]  pix;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    bit vedge;
    vedge   = vsync && !m_vprev;
    e_en    = 1'b0; e_we = 1'b0; e_rdy = 1'b0;
    e_addr  = 17'd0; e_wdata = 16'h0000;
    if (!rst && !vedge) begin
      if (m_q.size() + int'(m_pend) < 2) begin
        e_en   = 1'b1;
        e_addr = 17'(m_daddr);
      end else begin
        e_rdy = 1'b1;
        if (bus.wr_valid) begin
          e_en = 1'b1; e_we = 1'b1; e_addr = bus.wr_addr; e_wdata = bus.wr_data;
        end
      end
    end
  endtask

  task automatic model_edge();
    bit vedge;
    vedge = vsync && !m_vprev;
    if (rst) begin
      m_q.delete(); m_pend = 1'b0; m_sel = 0; m_daddr = 0;
      m_vprev = 1'b0; m_uf = 1'b0; m_pix = 4'd0;
    end else begin
      if (vedge) begin
        m_q.delete(); m_pend = 1'b0; m_sel = 0; m_daddr = 0; m_pix = 4'd0;
      end else begin
        if (!de) m_pix = 4'd0;
        else if (m_q.size() == 0) begin
          m_pix = 4'd0; m_uf = 1'b1;
        end else begin
          m_pix = 4'(m_q[0] >> (4 * m_sel));
          m_sel++;
          if (m_sel == 4) begin
            m_sel = 0;
            void'(m_q.pop_front());
          end
        end
        if (m_pend) m_q.push_back(m_pend_data);
        m_pend = 1'b0;
        if (e_en && !e_we) begin
          m_pend      = 1'b1;
          m_pend_data = vram[e_addr[9:0]];
          m_daddr     = (m_daddr + 1) % FW;
        end
      end
      m_vprev = vsync;
    end
  endtask

  // One clock: sample mid-cycle, check against the model, then step memory and model.
  task automatic tick();
    #3;
    model_comb();
    s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
    s_rdy = bus.wr_ready; s_pix = pixel; s_uf = underflow;
    s_acc = bus.wr_valid && bus.wr_ready;
    if (mchk) begin
      chk("mem_en", 32'(s_en), 32'(e_en));
      if (e_en) begin
        chk("mem_we", 32'(s_we), 32'(e_we));
        chk("mem_addr", 32'(s_addr), 32'(e_addr));
      end
      if (e_we) chk("mem_wdata", 32'(s_wdata), 32'(e_wdata));
      if (bus.wr_valid) chk("wr_ready", 32'(s_rdy), 32'(e_rdy));
      chk("pixel", 32'(s_pix), 32'(m_pix));
      chk("underflow", 32'(s_uf), 32'(m_uf));
    end
    @(posedge clk);
    rd_nxt = (s_en && !s_we) ? vram[s_addr[9:0]] : 16'($urandom);
    model_edge();
    if (s_en && s_we) vram[s_addr[9:0]] = s_wdata;
    #1;
    bus.mem_rdata = rd_nxt;
  endtask

  task automatic do_reset();
    rst = 1'b1; de = 1'b0; vsync = 1'b0; bus.wr_valid = 1'b0;
    tick();
    mchk = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int widx, n_rd, n_wr;
    bit found;
    for (int a = 0; a < 1024; a++) vram[a] = (a < FW) ? 16'((a * 40503) ^ 16'h5A5A) : 16'hDEAD;
    vram[0] = 16'h3210; vram[1] = 16'h7654; vram[2] = 16'hBA98; vram[3] = 16'hFEDC;
    tbl[0]  = '{1'b0, 1'b1, 17'd0, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 17'd1, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 17'd0, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 17'd0, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 17'd0, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 17'd0, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 17'd0, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 17'd0, 4'd2};
    tbl[8]  = '{1'b1, 1'b1, 17'd2, 4'd3};
    tbl[9]  = '{1'b1, 1'b0, 17'd0, 4'd4};
    tbl[10] = '{1'b1, 1'b0, 17'd0, 4'd5};
    tbl[11] = '{1'b1, 1'b0, 17'd0, 4'd6};
    tbl[12] = '{1'b0, 1'b1, 17'd3, 4'd7};
    tbl[13] = '{1'b0, 1'b0, 17'd0, 4'd0};
    mchk = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = 17'd0; bus.wr_data = 16'h0000; bus.mem_rdata = 16'h0000;
    @(posedge clk); #1;

    // reset state, then fill and pixel order from the vector table
    do_reset();
    chk("rst_mem_en", 32'(s_en), 32'd0);
    chk("rst_wr_ready", 32'(s_rdy), 32'd0);
    chk("rst_pixel", 32'(s_pix), 32'd0);
    chk("rst_underflow", 32'(s_uf), 32'd0);
    for (int i = 0; i < 14; i++) begin
      de = tbl[i].de;
      tick();
      chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'd0);
        chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].addr));
      end
      chk($sformatf("tbl%0d_pix", i), 32'(s_pix), 32'(tbl[i].pix));
      chk($sformatf("tbl%0d_uf", i), 32'(s_uf), 32'd0);
    end
    tick(); tick();

    // contention: writer always valid while video is active with a full FIFO
    de = 1'b1; widx = 0; n_rd = 0; n_wr = 0;
    for (int k = 0; k < 40; k++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 17'(800 + widx); bus.wr_data = 16'(16'h1000 + widx);
      tick();
      if (s_en && !s_we) n_rd++;
      else chk("cont_wr_ready", 32'(s_rdy), 32'd1);
      if (s_en && s_we) n_wr++;
      if (s_acc) widx++;
    end
    bus.wr_valid = 1'b0;
    chk("cont_dreads", 32'(n_rd), 32'd9);
    chk("cont_mem_writes", 32'(n_wr), 32'd31);
    chk("cont_accepts", 32'(widx), 32'd31);
    for (int i = 0; i < 31; i++) chk("cont_data", 32'(vram[800 + i]), 32'(16'h1000 + i));
    chk("cont_no_extra", 32'(vram[831]), 32'hDEAD);

    // wrap of the display address at the last frame word
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      tick();
      if (s_en && !s_we && s_addr == 17'd599) found = 1'b1;
    end
    chk("wait_addr599", 32'(found), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (s_en && !s_we) begin
        found = 1'b1;
        chk("wrap_addr", 32'(s_addr), 32'd0);
      end
    end
    chk("wait_wrap_read", 32'(found), 32'd1);

    // frame restart while the read of address 500 is in flight
    found = 1'b0;
    for (int k = 0; k < 2500 && !found; k++) begin
      tick();
      if (s_en && !s_we && s_addr == 17'd500) found = 1'b1;
    end
    chk("wait_addr500", 32'(found), 32'd1);
    vsync = 1'b1; de = 1'b0;
    tick();
    chk("vsync_no_access", 32'(s_en), 32'd0);
    tick();
    chk("restart_en", 32'(s_en), 32'd1);
    chk("restart_addr", 32'(s_addr), 32'd0);
    vsync = 1'b0;
    tick(); tick();
    de = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) chk("restart_pixel", 32'(s_pix), 32'(i - 1));
    end
    chk("restart_no_underflow", 32'(s_uf), 32'd0);

    // underflow: display active straight out of reset
    do_reset();
    de = 1'b1;
    tick();
    tick();
    chk("uf_set", 32'(s_uf), 32'd1);
    chk("uf_pixel", 32'(s_pix), 32'd0);
    for (int k = 0; k < 20; k++) tick();
    chk("uf_sticky", 32'(s_uf), 32'd1);
    do_reset();
    chk("uf_cleared", 32'(s_uf), 32'd0);

    // reset asserted in a write cycle
    for (int k = 0; k < 4; k++) tick();
    bus.wr_valid = 1'b1; bus.wr_addr = 17'd900; bus.wr_data = 16'hBEEF; rst = 1'b1;
    tick();
    chk("rstw_mem_en", 32'(s_en), 32'd0);
    chk("rstw_wr_ready", 32'(s_rdy), 32'd0);
    bus.wr_valid = 1'b0;
    tick();
    chk("rstw_en2", 32'(s_en), 32'd0);
    chk("rstw_we2", 32'(s_we), 32'd0);
    chk("rstw_addr2", 32'(s_addr), 32'd0);
    chk("rstw_wdata2", 32'(s_wdata), 32'd0);
    chk("rstw_pixel", 32'(s_pix), 32'd0);
    chk("rstw_uf", 32'(s_uf), 32'd0);
    rst = 1'b0;
    chk("rstw_no_write", 32'(vram[900]), 32'hDEAD);
    tick();
    chk("rstw_first_read", 32'(s_addr), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      de = ($urandom_range(0, 4) != 0);
      if (vsync) vsync = ($urandom_range(0, 3) != 0);
      else vsync = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if (!bus.wr_valid && $urandom_range(0, 2) == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 17'($urandom_range(0, 1023));
        bus.wr_data  = 16'($urandom);
      end
      tick();
      if (s_acc || rst) bus.wr_valid = 1'b0;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
